boot_handover_arbiter: RTL

//  Owns the shared instruction-memory write port and byte IO port, and hands them

---
 rtl/boot_handover_arbiter_pkg.sv | 19 +
 rtl/boot_handover_arbiter_if.sv | 60 ++++++
 rtl/boot_handover_arbiter_delay_counter.sv | 28 ++
 rtl/boot_handover_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/boot_handover_arbiter_pkg.sv
// Shared types for the boot handover arbiter: FSM encoding and ownership helper.
package boot_handover_arbiter_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_BOOT    = 3'd0,
        S_DRAIN   = 3'd1,
        S_DELAY   = 3'd2,
        S_RUN     = 3'd3,
        S_QUIESCE = 3'd4
    } state_t;

    // The core owns the muxed ports from DELAY onward, until it returns to BOOT.
    function automatic logic core_owns(input state_t st);
        return (st == S_DELAY) || (st == S_RUN) || (st == S_QUIESCE);
    endfunction

endpackage

// File: rtl/boot_handover_arbiter_if.sv
// Bundle of bootloader, controller, memory and IO signals around the arbiter.
// Handshake: an IO request is accepted in any cycle where
// (io_read_req | io_write_req) & io_ready is 1; it stays outstanding until io_done.
interface boot_handover_arbiter_if
    import boot_handover_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IO_W   = 8,
    parameter int ERR_W  = 4
);
    logic [ADDR_W-1:0]   boot_inst_addr;
    logic [DATA_W-1:0]   boot_inst_wdata;
    logic [DATA_W/8-1:0] boot_inst_we;
    logic                boot_inst_en;
    logic                boot_io_read_req;
    logic                boot_done;
    logic [ADDR_W-1:0]   boot_entry;
    logic [ERR_W-1:0]    boot_err;
    logic [ADDR_W-1:0]   core_inst_addr;
    logic                core_inst_en;
    logic                core_io_read_req;
    logic                core_io_write_req;
    logic [IO_W-1:0]     core_io_wdata;
    logic [ERR_W-1:0]    core_err;
    logic                reboot_req;
    logic                io_ready;
    logic                io_done;
    logic [ADDR_W-1:0]   inst_addr;
    logic [DATA_W-1:0]   inst_wdata;
    logic [DATA_W/8-1:0] inst_we;
    logic                inst_en;
    logic                io_read_req;
    logic                io_write_req;
    logic [IO_W-1:0]     io_wdata;
    logic                core_run;
    logic [ADDR_W-1:0]   core_entry;
    logic                boot_restart;
    logic                boot_ready;
    logic [2*ERR_W-1:0]  err;
    logic [STATE_W-1:0]  state;

    modport master (
        input  boot_inst_addr, boot_inst_wdata, boot_inst_we, boot_inst_en,
               boot_io_read_req, boot_done, boot_entry, boot_err,
               core_inst_addr, core_inst_en, core_io_read_req, core_io_write_req,
               core_io_wdata, core_err, reboot_req, io_ready, io_done,
        output inst_addr, inst_wdata, inst_we, inst_en, io_read_req, io_write_req,
               io_wdata, core_run, core_entry, boot_restart, boot_ready, err, state
    );

    modport slave (
        output boot_inst_addr, boot_inst_wdata, boot_inst_we, boot_inst_en,
               boot_io_read_req, boot_done, boot_entry, boot_err,
               core_inst_addr, core_inst_en, core_io_read_req, core_io_write_req,
               core_io_wdata, core_err, reboot_req, io_ready, io_done,
        input  inst_addr, inst_wdata, inst_we, inst_en, io_read_req, io_write_req,
               io_wdata, core_run, core_entry, boot_restart, boot_ready, err, state
    );
endinterface

// File: rtl/boot_handover_arbiter_delay_counter.sv
// Settle-delay counter: counts while start is high, flags the last cycle, never wraps.
module handover_delay_counter #(
    parameter int CNT_W          = 32,
    parameter int HANDOVER_DELAY = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             clear,
    output logic             expire,
    output logic [CNT_W-1:0] cnt
);
    // With a zero delay the counter is never started, so the compare value is moot.
    localparam logic [CNT_W-1:0] LAST = (HANDOVER_DELAY > 0) ? CNT_W'(HANDOVER_DELAY - 1) : '0;

    assign expire = start && (cnt == LAST);

    // Count up from 0 while started; return to 0 on expiry or when cleared.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clear || expire) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/boot_handover_arbiter.sv
// Hands the instruction-memory write port and byte IO port from the bootloader to
// the core controller (boot, IO drain, settle delay, run) and back on soft reboot.
module boot_handover_arbiter
    import boot_handover_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int IO_W           = 8,
    parameter int ERR_W          = 4,
    parameter int HANDOVER_DELAY = 16,
    parameter int CNT_W          = 32
) (
    input logic                     CLK,
    input logic                     RSTN,
    boot_handover_arbiter_if.master bus
);
    state_t              state_q;
    state_t              state_d;
    logic                outstanding;
    logic                cnt_expire;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   core_entry_q;
    logic                boot_restart_q;
    logic [ADDR_W-1:0]   inst_addr;
    logic [DATA_W-1:0]   inst_wdata;
    logic [DATA_W/8-1:0] inst_we;
    logic                inst_en;
    logic                io_rd;
    logic                io_wr;
    logic [IO_W-1:0]     io_wdata;
    logic                core_run;

    handover_delay_counter #(
        .CNT_W          (CNT_W),
        .HANDOVER_DELAY (HANDOVER_DELAY)
    ) u_cnt (
        .clk    (CLK),
        .rstn   (RSTN),
        .start  (state_q == S_DELAY),
        .clear  (state_q != S_DELAY),
        .expire (cnt_expire),
        .cnt    (cnt)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; boot_done and reboot_req only matter in BOOT and RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:    if (bus.boot_done) state_d = S_DRAIN;
            S_DRAIN:   if (!outstanding) state_d = (HANDOVER_DELAY == 0) ? S_RUN : S_DELAY;
            S_DELAY:   if (cnt_expire) state_d = S_RUN;
            S_RUN:     if (bus.reboot_req) state_d = S_QUIESCE;
            S_QUIESCE: if (!outstanding) state_d = S_BOOT;
            default:   state_d = S_BOOT;
        endcase
    end

    // Ownership muxes, decoded from the registered state only.
    always_comb begin
        inst_addr  = bus.boot_inst_addr;
        inst_wdata = bus.boot_inst_wdata;
        inst_we    = '0;
        inst_en    = 1'b0;
        io_rd      = 1'b0;
        io_wr      = 1'b0;
        io_wdata   = '0;
        core_run   = 1'b0;
        case (state_q)
            S_BOOT: begin
                inst_we = bus.boot_inst_we;
                inst_en = bus.boot_inst_en;
                io_rd   = bus.boot_io_read_req;
            end
            S_DRAIN: begin
                inst_we = bus.boot_inst_we;
                inst_en = bus.boot_inst_en;
            end
            S_DELAY: begin
                inst_addr  = bus.core_inst_addr;
                inst_wdata = '0;
                inst_en    = bus.core_inst_en;
            end
            S_RUN: begin
                inst_addr  = bus.core_inst_addr;
                inst_wdata = '0;
                inst_en    = bus.core_inst_en;
                io_rd      = bus.core_io_read_req;
                io_wr      = bus.core_io_write_req;
                io_wdata   = bus.core_io_wdata;
                core_run   = 1'b1;
            end
            S_QUIESCE: begin
                inst_addr  = bus.core_inst_addr;
                inst_wdata = '0;
            end
            default: ;
        endcase
    end

    // Outstanding IO tracker; a new acceptance wins over a same-cycle completion.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            outstanding <= 1'b0;
        end else if ((io_rd || io_wr) && bus.io_ready) begin
            outstanding <= 1'b1;
        end else if (bus.io_done) begin
            outstanding <= 1'b0;
        end
    end

    // Entry point latch and the one-cycle restart pulse on QUIESCE -> BOOT.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            core_entry_q   <= '0;
            boot_restart_q <= 1'b0;
        end else begin
            if (state_q == S_BOOT && bus.boot_done) begin
                core_entry_q <= bus.boot_entry;
            end
            boot_restart_q <= (state_q == S_QUIESCE) && !outstanding;
        end
    end

    assign bus.inst_addr    = inst_addr;
    assign bus.inst_wdata   = inst_wdata;
    assign bus.inst_we      = inst_we;
    assign bus.inst_en      = inst_en;
    assign bus.io_read_req  = io_rd;
    assign bus.io_write_req = io_wr;
    assign bus.io_wdata     = io_wdata;
    assign bus.core_run     = core_run;
    assign bus.core_entry   = core_entry_q;
    assign bus.boot_restart = boot_restart_q;
    assign bus.boot_ready   = core_owns(state_q);
    assign bus.err          = {bus.core_err, bus.boot_err};
    assign bus.state        = state_q;
endmodule
